// File: rtl/mem_block_responder_pkg.sv
// Purpose : shared types and constants for the cache block interface (the cache
//           uses the same block geometry for its index math).
// Contents: resp_state_t responder FSM states, BL_NUM_BYTES block size,
//           BL_OFFSET_W byte-offset width, CNT_W latency counter width.
package mem_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_DONE,
    STORE_WAIT,
    STORE_DONE
  } resp_state_t;

  localparam int unsigned BL_NUM_BYTES = 4;
  localparam int unsigned BL_OFFSET_W  = $clog2(BL_NUM_BYTES);
  // Wide enough for the largest legal latency (15)
  localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/mem_block_responder_if.sv
// Purpose : cache <-> memory block bus, four-phase req/completed handshake.
// Signals : address_in, data_in, mem_load_req, mem_store_req (cache -> memory);
//           data_out, load_completed, store_completed, load_toggle, busy
//           (memory -> cache).
// Modports: master (cache side), slave (memory responder side).
interface mem_block_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] address_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              mem_load_req;
  logic              mem_store_req;
  logic              load_completed;
  logic              store_completed;
  logic              load_toggle;
  logic              busy;

  modport master (
    output address_in, data_in, mem_load_req, mem_store_req,
    input  data_out, load_completed, store_completed, load_toggle, busy
  );

  modport slave (
    input  address_in, data_in, mem_load_req, mem_store_req,
    output data_out, load_completed, store_completed, load_toggle, busy
  );
endinterface

// File: rtl/mem_block_responder_array.sv
// Purpose : block storage, DEPTH x DATA_W, synchronous write port and
//           asynchronous read port; contents are never reset.
// Ports   : clk, i_wr_en, i_wr_idx, i_wr_data (write); i_rd_idx, o_rd_data (read).
// INIT_PAT: each entry is kept XORed with its own index, so an array that
//           starts zero-filled reads back as mem[i] = i; INIT_PAT=0 stores raw.
module mem_block_array #(
  parameter int unsigned IDX_W    = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INIT_PAT = 1
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Per-entry pattern value folded into storage
  function automatic logic [DATA_W-1:0] pat(input logic [IDX_W-1:0] idx);
    return (INIT_PAT != 0) ? DATA_W'(idx) : '0;
  endfunction

  // Write port
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data ^ pat(i_wr_idx);
  end

  // Read port
  assign o_rd_data = r_mem[i_rd_idx] ^ pat(i_rd_idx);

endmodule

// File: rtl/mem_block_responder.sv
// Purpose : memory-side responder for cache block loads/stores with a
//           programmable response latency (LATENCY edges from acceptance to
//           completed, legal range 1..15).
// Ports   : clk, rst_n (async active-low), bus (mem_block_responder_if.slave).
// Notes   : store wins when both requests are high in IDLE; dropping the owning
//           request while waiting aborts without side effects.
module mem_block_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LATENCY  = 3,
  parameter int unsigned INIT_PAT = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_block_responder_if.slave bus
);
  localparam int unsigned IDX_W = ADDR_W - BL_OFFSET_W;

  resp_state_t        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_load_done;
  logic               r_store_done;
  logic               r_busy;

  logic [DATA_W-1:0]  w_rdata;
  logic               w_cnt_zero;
  logic               w_wr_en;
  logic               w_unused_offset;

  assign w_cnt_zero = (r_cnt == '0);
  // Commit happens on the same edge that raises store_completed
  assign w_wr_en    = (r_state == STORE_WAIT) && bus.mem_store_req && w_cnt_zero;
  // Byte offset within a block carries no meaning here
  assign w_unused_offset = ^bus.address_in[BL_OFFSET_W-1:0];

  mem_block_array #(
    .IDX_W    (IDX_W),
    .DATA_W   (DATA_W),
    .INIT_PAT (INIT_PAT)
  ) u_array (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (r_wdata),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rdata)
  );

  // Handshake FSM, latency counter and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_data_out   <= '0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mem_store_req) begin
            r_idx   <= bus.address_in[ADDR_W-1:BL_OFFSET_W];
            r_wdata <= bus.data_in;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= STORE_WAIT;
          end else if (bus.mem_load_req) begin
            r_idx   <= bus.address_in[ADDR_W-1:BL_OFFSET_W];
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (!bus.mem_load_req) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_cnt_zero) begin
            r_data_out  <= w_rdata;
            r_load_done <= 1'b1;
            r_state     <= LOAD_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        LOAD_DONE: begin
          if (!bus.mem_load_req) begin
            r_load_done <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        STORE_WAIT: begin
          if (!bus.mem_store_req) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_cnt_zero) begin
            r_store_done <= 1'b1;
            r_state      <= STORE_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STORE_DONE: begin
          if (!bus.mem_store_req) begin
            r_store_done <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_load_done  <= 1'b0;
          r_store_done <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out        = r_data_out;
  assign bus.load_completed  = r_load_done;
  assign bus.store_completed = r_store_done;
  assign bus.busy            = r_busy;
  // Single-beat responder: no burst beats to mark
  assign bus.load_toggle     = 1'b0;

endmodule

// File: tb/tb_mem_block_responder.sv
// Purpose: directed self-checking bench for mem_block_responder (LATENCY=3,
//          INIT_PAT=1, so unwritten block i reads back as i).
module tb_mem_block_responder;
  localparam int unsigned LAT = 3;
  localparam int unsigned TMO = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_block_responder_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_block_responder #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .LATENCY  (LAT),
    .INIT_PAT (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full load transaction from IDLE; returns the cycle of acceptance
  task automatic do_load(input logic [15:0] addr, input logic [31:0] exp,
                         input string tag, output int acc);
    int n;
    bus.address_in   = addr;
    bus.mem_load_req = 1'b1;
    tick();
    acc = cyc;
    check({tag, " busy_on_accept"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.load_completed !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT));
    check({tag, " data"}, bus.data_out, exp);
    bus.mem_load_req = 1'b0;
    tick();
    check({tag, " completed_drop"}, 32'(bus.load_completed), 32'd0);
    check({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, " data_hold"}, bus.data_out, exp);
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [31:0] data, input string tag);
    int n;
    bus.address_in    = addr;
    bus.data_in       = data;
    bus.mem_store_req = 1'b1;
    tick();
    n = 0;
    while (bus.store_completed !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT));
    bus.mem_store_req = 1'b0;
    tick();
    check({tag, " completed_drop"}, 32'(bus.store_completed), 32'd0);
  endtask

  logic [15:0] b2b_addr [4] = '{16'h0000, 16'h0004, 16'h0008, 16'h003C};
  logic [31:0] b2b_exp  [4] = '{32'h0000_0000, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_000F};

  int   n, acc, acc_prev;
  logic overlap, seen;

  initial begin
    bus.address_in    = '0;
    bus.data_in       = '0;
    bus.mem_load_req  = 1'b0;
    bus.mem_store_req = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst load_completed", 32'(bus.load_completed), 32'd0);
    check("rst store_completed", 32'(bus.store_completed), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst data_out", bus.data_out, 32'd0);
    check("rst load_toggle", 32'(bus.load_toggle), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain load of pattern contents
    do_load(16'h0010, 32'h0000_0004, "load_0x10", acc);

    // Store then load through an address with nonzero byte offset
    do_store(16'h0008, 32'hDEAD_BEEF, "store_0x08");
    do_load(16'h000A, 32'hDEAD_BEEF, "load_0x0A", acc);

    // Simultaneous requests: store first, load after, never overlapping
    overlap = 1'b0;
    bus.address_in    = 16'h0030;
    bus.data_in       = 32'h1234_5678;
    bus.mem_store_req = 1'b1;
    bus.mem_load_req  = 1'b1;
    tick();
    n = 0;
    while (bus.store_completed !== 1'b1 && n < TMO) begin
      if (bus.load_completed === 1'b1) overlap = 1'b1;
      tick();
      n++;
    end
    check("both store_latency", 32'(n), 32'(LAT));
    check("both load_held_off", 32'(bus.load_completed), 32'd0);
    bus.mem_store_req = 1'b0;
    tick();
    check("both store_drop", 32'(bus.store_completed), 32'd0);
    n = 0;
    while (bus.load_completed !== 1'b1 && n < TMO) begin
      if (bus.store_completed === 1'b1) overlap = 1'b1;
      tick();
      n++;
    end
    check("both load_total", 32'(n), 32'(LAT + 1));
    check("both load_data", bus.data_out, 32'h1234_5678);
    check("both no_overlap", 32'(overlap), 32'd0);
    bus.mem_load_req = 1'b0;
    tick();
    check("both load_drop", 32'(bus.load_completed), 32'd0);

    // Abort a store after one cycle: no completion, no write
    bus.address_in    = 16'h0020;
    bus.data_in       = 32'hCAFE_F00D;
    bus.mem_store_req = 1'b1;
    tick();
    bus.mem_store_req = 1'b0;
    tick();
    check("abort busy", 32'(bus.busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.store_completed === 1'b1) seen = 1'b1;
    end
    check("abort no_completed", 32'(seen), 32'd0);
    do_load(16'h0020, 32'h0000_0008, "abort_readback", acc);

    // Reset during STORE_WAIT: store is lost, committed data survives
    bus.address_in    = 16'h0040;
    bus.data_in       = 32'h55AA_55AA;
    bus.mem_store_req = 1'b1;
    tick();
    tick();
    check("rstmid busy_before", 32'(bus.busy), 32'd1);
    rst_n             = 1'b0;
    bus.mem_store_req = 1'b0;
    #1;
    check("rstmid busy", 32'(bus.busy), 32'd0);
    check("rstmid data_out", bus.data_out, 32'd0);
    tick();
    tick();
    check("rstmid store_completed", 32'(bus.store_completed), 32'd0);
    check("rstmid load_completed", 32'(bus.load_completed), 32'd0);
    rst_n = 1'b1;
    tick();
    do_load(16'h0040, 32'h0000_0010, "rstmid no_write", acc);
    do_load(16'h0008, 32'hDEAD_BEEF, "rstmid persist", acc);

    // Back-to-back loads at minimum spacing
    acc_prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_load(b2b_addr[i], b2b_exp[i], $sformatf("b2b%0d", i), acc);
      if (i > 0) check($sformatf("b2b%0d spacing", i), 32'(acc - acc_prev), 32'(LAT + 2));
      acc_prev = acc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
